// File: rtl/vedic_pkg.sv
// Shared definitions for the pipelined Vedic multiplier: elaboration checks,
// pipeline depth and the per-stage control word.
package vedic_pkg;

    localparam int LATENCY = 3;
    localparam int TAG_MAX = 16;

    // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
    typedef struct packed {
        logic               valid;
        logic               neg;
        logic [TAG_MAX-1:0] tag;
    } stage_ctrl_t;

    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational unsigned H x H Urdhva Tiryagbhyam multiplier, built recursively
// from four half-width cores down to a 2x2 crosswise base cell.
module vedic_core #(
    parameter int H = 4
) (
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-1:0] p_o
);

    localparam int P = 2 * H;
    localparam int Q = H / 2;

    generate
        if (H == 2) begin : g_base
            logic x0, x1, cross_c;
            assign x0      = a_i[1] & b_i[0];
            assign x1      = a_i[0] & b_i[1];
            assign cross_c = x0 & x1;
            assign p_o[0]  = a_i[0] & b_i[0];
            assign p_o[1]  = x0 ^ x1;
            assign p_o[2]  = (a_i[1] & b_i[1]) ^ cross_c;
            assign p_o[3]  = (a_i[1] & b_i[1]) & cross_c;
        end else begin : g_rec
            logic [H-1:0] q0, q1, q2, q3;

            vedic_core #(.H(Q)) u_ll (.a_i(a_i[Q-1:0]), .b_i(b_i[Q-1:0]), .p_o(q0));
            vedic_core #(.H(Q)) u_lh (.a_i(a_i[Q-1:0]), .b_i(b_i[H-1:Q]), .p_o(q1));
            vedic_core #(.H(Q)) u_hl (.a_i(a_i[H-1:Q]), .b_i(b_i[Q-1:0]), .p_o(q2));
            vedic_core #(.H(Q)) u_hh (.a_i(a_i[H-1:Q]), .b_i(b_i[H-1:Q]), .p_o(q3));

            assign p_o = P'(q0) + (P'(q1) << Q) + (P'(q2) << Q) + (P'(q3) << H);
        end
    endgenerate

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Vedic multiplier (sign, partial products, accumulate)
// with a signed/unsigned mode and a tag carried alongside each operand pair.
module vedic_mult_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;

    generate
        if (!width_ok(WIDTH) || (TAG_W < 1) || (TAG_W > TAG_MAX)) begin : g_bad_param
            $error("vedic_mult_pipe: WIDTH must be a power of two >= 4 and TAG_W in 1..TAG_MAX");
        end
    endgenerate

    // Handshake: a pair transfers in when in_valid && in_ready, a result transfers
    // out when out_valid && out_ready. The whole pipeline advances together
    // (adv = !out_valid || out_ready) and holds every stage otherwise.
    logic adv;

    stage_ctrl_t        s1_d, s1_q, s2_q, s3_q;
    logic [WIDTH-1:0]   s1_a_d, s1_b_d, s1_a_q, s1_b_q;
    logic [WIDTH-1:0]   pp0_d, pp1_d, pp2_d, pp3_d;
    logic [WIDTH-1:0]   pp0_q, pp1_q, pp2_q, pp3_q;
    logic [W2-1:0]      mag_d, prod_d, prod_q;
    logic               unused_tag_hi;

    assign adv      = !s3_q.valid || out_ready;
    assign in_ready = adv;

    // Most-negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.neg   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        s1_d.tag   = TAG_MAX'(in_tag);
        s1_a_d     = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
        s1_b_d     = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
    end

    vedic_core #(.H(H)) u_pp0 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[H-1:0]),     .p_o(pp0_d));
    vedic_core #(.H(H)) u_pp1 (.a_i(s1_a_q[H-1:0]),     .b_i(s1_b_q[WIDTH-1:H]), .p_o(pp1_d));
    vedic_core #(.H(H)) u_pp2 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]),     .p_o(pp2_d));
    vedic_core #(.H(H)) u_pp3 (.a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(pp3_d));

    always_comb begin
        mag_d  = W2'(pp0_q) + (W2'(pp1_q) << H) + (W2'(pp2_q) << H) + (W2'(pp3_q) << WIDTH);
        prod_d = s2_q.neg ? (~mag_d + W2'(1)) : mag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            s1_a_q <= '0;
            s1_b_q <= '0;
            pp0_q  <= '0;
            pp1_q  <= '0;
            pp2_q  <= '0;
            pp3_q  <= '0;
            prod_q <= '0;
        end else if (adv) begin
            s1_q   <= s1_d;
            s1_a_q <= s1_a_d;
            s1_b_q <= s1_b_d;
            s2_q   <= s1_q;
            pp0_q  <= pp0_d;
            pp1_q  <= pp1_d;
            pp2_q  <= pp2_d;
            pp3_q  <= pp3_d;
            s3_q   <= s2_q;
            prod_q <= prod_d;
        end
    end

    assign out_valid     = s3_q.valid;
    assign out_prod      = prod_q;
    assign out_tag       = s3_q.tag[TAG_W-1:0];
    assign unused_tag_hi = ^s3_q.tag;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe at WIDTH=8: reset, latency, signed corners,
// back-to-back streaming, stall hold and mid-flight reset.
module tb_vedic_mult_pipe;

    localparam int WIDTH = 8;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               in_signed = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2*WIDTH-1:0] out_prod;
    logic [TAG_W-1:0]   out_tag;

    int checks = 0;
    int errors = 0;

    logic [19:0]      exp_q[$];
    logic [WIDTH-1:0] va[8];
    logic [WIDTH-1:0] vb[8];
    logic             vs[8];
    logic [15:0]      vexp[8];

    vedic_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic [15:0] e);
        va[i] = a;
        vb[i] = b;
        vs[i] = s;
        vexp[i] = e;
    endtask

    // One isolated pair: result must be absent for LATENCY-1 edges, then present.
    task automatic send_one(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [3:0] tag, input logic [15:0] e);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        #1;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k < vedic_pkg::LATENCY; k++) begin
            check({name, "_early"}, 32'(out_valid), 32'd0);
            step();
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_prod"}, 32'(out_prod), 32'(e));
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
        check({name, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    // Streams vectors 0..n-1 with out_ready low during cycles [st_lo, st_hi).
    task automatic run_stream(input string name, input int n, input int st_lo, input int st_hi,
                              output int first_x, output int last_x);
        int          sent;
        int          got;
        logic        held_v;
        logic [19:0] held;
        sent = 0;
        got = 0;
        held_v = 1'b0;
        held = '0;
        first_x = -1;
        last_x = -1;
        for (int c = 0; c < 60 && got < n; c++) begin
            out_ready = !(c >= st_lo && c < st_hi);
            in_valid  = (sent < n);
            if (sent < n) begin
                in_a      = va[sent];
                in_b      = vb[sent];
                in_signed = vs[sent];
                in_tag    = sent[3:0];
            end
            #1;
            if (out_valid && !out_ready)
                check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            if (held_v)
                check({name, "_stall_hold"}, 32'({out_tag, out_prod}), 32'(held));
            held_v = out_valid && !out_ready;
            held   = {out_tag, out_prod};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check({name, "_spurious"}, 32'({out_tag, out_prod}), 32'hFFFFFFFF);
                else
                    check({name, "_data"}, 32'({out_tag, out_prod}), 32'(exp_q.pop_front()));
                got++;
                if (first_x < 0) first_x = c;
                last_x = c;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({sent[3:0], vexp[sent]});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({name, "_count"}, 32'(got), 32'(n));
        check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int first_x;
        int last_x;

        // Reset values
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prod", 32'(out_prod), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed corner products
        send_one("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 4'h5, 16'hFE01);
        send_one("s_80_80", 8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
        send_one("s_80_7f", 8'h80, 8'h7F, 1'b1, 4'h2, 16'hC080);
        send_one("s_ff_05", 8'hFF, 8'h05, 1'b1, 4'h3, 16'hFFFB);
        send_one("u_ff_05", 8'hFF, 8'h05, 1'b0, 4'h4, 16'h04FB);

        // Back-to-back stream, mixed modes, no stalls
        set_vec(0, 8'h03, 8'h04, 1'b0, 16'h000C);
        set_vec(1, 8'hFE, 8'h03, 1'b1, 16'hFFFA);
        set_vec(2, 8'h80, 8'h02, 1'b0, 16'h0100);
        set_vec(3, 8'h7F, 8'h7F, 1'b1, 16'h3F01);
        set_vec(4, 8'h10, 8'h10, 1'b0, 16'h0100);
        set_vec(5, 8'h81, 8'h02, 1'b1, 16'hFF02);
        set_vec(6, 8'hFF, 8'h01, 1'b0, 16'h00FF);
        set_vec(7, 8'h00, 8'h80, 1'b1, 16'h0000);
        run_stream("stream", 8, -1, -1, first_x, last_x);
        check("stream_first", 32'(first_x), 32'(vedic_pkg::LATENCY));
        check("stream_span", 32'(last_x - first_x), 32'd7);

        // Stream with a 5-cycle downstream stall
        set_vec(0, 8'h0F, 8'h0F, 1'b0, 16'h00E1);
        set_vec(1, 8'hF0, 8'h10, 1'b1, 16'hFF00);
        set_vec(2, 8'hC8, 8'h02, 1'b0, 16'h0190);
        set_vec(3, 8'h80, 8'hFF, 1'b1, 16'h0080);
        set_vec(4, 8'h00, 8'hFF, 1'b0, 16'h0000);
        set_vec(5, 8'h7F, 8'h80, 1'b1, 16'hC080);
        run_stream("stall", 6, 3, 8, first_x, last_x);
        check("stall_first", 32'(first_x), 32'd8);

        // Reset with three transactions in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_a      = 8'h11 + 8'(i);
            in_b      = 8'h22;
            in_signed = 1'b0;
            in_tag    = 4'(i + 8);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_prod", 32'(out_prod), 32'd0);
        check("midrst_out_tag", 32'(out_tag), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Pipeline still healthy after reset
        send_one("post_rst", 8'h0C, 8'h0D, 1'b0, 4'hA, 16'h009C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
